// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-limited sharing of one FIFO write port
// Optional build macro FIFO_WR_ARB_LOCK_EN adds the lock input.
// Ports: wclk/wrst     write clock, sync active-high reset
//        req/wr_data   per-requester word-available level and flattened data
//        full          FIFO full flag
//        lock          (FIFO_WR_ARB_LOCK_EN) per-requester burst-limit override
//        ack/w_en      word consumed this cycle (combinational)
//        gnt/busy      registered current owner, grant-held flag
//        data_in       granted requester's word, 0 when idle
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          wclk,
    input  logic                          wrst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wr_data,
    input  logic                          full,
`ifdef FIFO_WR_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]            lock,
`endif
    output logic [NUM_REQ-1:0]            ack,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          w_en,
    output logic [DATA_WIDTH-1:0]         data_in,
    output logic                          busy
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t             st, st_n;
    logic [NUM_REQ-1:0] gnt_n, excl;
    logic [BW-1:0]      burst_cnt, cnt_n;
    logic [PW-1:0]      prio_ptr, ptr_n, g, g_nxt;
    logic               last, lock_g, lim, rel;

    // First set bit of m at or after p, wrapping modulo NUM_REQ, as one-hot.
    function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] m, input logic [PW-1:0] p);
        logic [NUM_REQ-1:0] r;
        logic               found;
        logic [PW-1:0]      j;
        int                 jj;
        r     = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            jj = int'(p) + k;
            jj = (jj >= NUM_REQ) ? jj - NUM_REQ : jj;
            j  = PW'(jj);
            if (!found && m[j]) begin
                r[j]  = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    always_comb begin
        g       = '0;
        data_in = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) g = PW'(i);
            data_in = data_in | ({DATA_WIDTH{gnt[i]}} & wr_data[i*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

`ifdef FIFO_WR_ARB_LOCK_EN
    assign lock_g = lock[g];
`else
    assign lock_g = 1'b0;
`endif

    // Reset gates the write port immediately, before gnt is cleared at the edge.
    assign ack   = gnt & req & {NUM_REQ{~full & ~wrst}};
    assign w_en  = |ack;
    assign last  = burst_cnt == BW'(MAX_BURST - 1);
    assign lim   = w_en & last & ~lock_g;
    assign rel   = ~req[g] | lim;
    assign g_nxt = (g == PW'(NUM_REQ - 1)) ? '0 : g + 1'b1;
    // A burst-limited owner sits out the re-grant it triggers.
    assign excl  = lim ? gnt : '0;

    always_comb begin
        st_n  = st;
        gnt_n = gnt;
        cnt_n = burst_cnt;
        ptr_n = prio_ptr;
        if (st == IDLE) begin
            if (|req) begin
                gnt_n = rr_pick(req, prio_ptr);
                cnt_n = '0;
                st_n  = OWN;
            end
        end else if (rel) begin
            ptr_n = g_nxt;
            gnt_n = rr_pick(req & ~excl, g_nxt);
            cnt_n = '0;
            st_n  = (|gnt_n) ? OWN : IDLE;
        end else if (w_en && !last) begin
            cnt_n = burst_cnt + 1'b1;
        end
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            st        <= IDLE;
            gnt       <= '0;
            burst_cnt <= '0;
            prio_ptr  <= '0;
            busy      <= 1'b0;
        end else begin
            st        <= st_n;
            gnt       <= gnt_n;
            burst_cnt <= cnt_n;
            prio_ptr  <= ptr_n;
            busy      <= st_n == OWN;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: randomized and directed checks against an owner/word-count reference model
module tb_fifo_wr_arbiter;
    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int MB    = 4;
    localparam int BOUND = (N - 1) * (MB + 1);

    logic            wclk = 1'b0;
    logic            wrst = 1'b1;
    logic            full = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] wr_data = '0;
    logic [N-1:0]    lock_v = '0;
    logic [N-1:0]    ack, gnt;
    logic            w_en, busy;
    logic [DW-1:0]   data_in;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .wclk(wclk), .wrst(wrst), .req(req), .wr_data(wr_data), .full(full),
`ifdef FIFO_WR_ARB_LOCK_EN
        .lock(lock_v),
`endif
        .ack(ack), .gnt(gnt), .w_en(w_en), .data_in(data_in), .busy(busy)
    );

    always #5 wclk = ~wclk;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            owner   = -1;
    int            cnt     = 0;
    int            ptr     = 0;
    int            left[N];
    int            wt[N];
    bit            has[N];
    logic [DW-1:0] wd[N];
    logic [DW-1:0] nw = 8'h01;
    logic [31:0]   pat;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++)
            if (m[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic bit quiet();
        quiet = owner < 0;
        for (int i = 0; i < N; i++) quiet = quiet && !has[i] && left[i] == 0;
    endfunction

    task automatic grant_to(input logic [N-1:0] m, input int p);
        owner = pick(m, p);
        cnt   = 0;
        if (owner >= 0) begin
            check("fair", 32'(wt[owner] <= BOUND), 1);
            wt[owner] = 0;
        end
    endtask

    task automatic cycle(input int p_req, input bit f, input bit r);
        logic [N-1:0]  eg, ea, m;
        logic [DW-1:0] ed;
        bit            lim;
        for (int i = 0; i < N; i++)
            if (!has[i] && left[i] > 0 && $urandom_range(0, 99) < p_req) begin
                has[i] = 1'b1;
                wd[i]  = nw;
                nw     = nw + 8'd1;
                left[i]--;
            end
        wrst = r;
        full = f;
        for (int i = 0; i < N; i++) begin
            req[i] = has[i];
            wr_data[i*DW +: DW] = wd[i];
        end
        @(negedge wclk);
        eg = (owner >= 0) ? N'(1) << owner : '0;
        ea = (owner >= 0 && req[owner] && !f && !r) ? eg : '0;
        ed = (owner >= 0) ? wd[owner] : '0;
        check("gnt", 32'(gnt), 32'(eg));
        check("ack", 32'(ack), 32'(ea));
        check("w_en", 32'(w_en), 32'(|ea));
        check("data_in", 32'(data_in), 32'(ed));
        check("busy", 32'(busy), 32'(owner >= 0));
        pat = {pat[30:0], w_en};
        for (int i = 0; i < N; i++)
            wt[i] = (!req[i] || r || owner == i) ? 0 : wt[i] + ((f) ? 0 : 1);
        if (ea != 0) has[owner] = 1'b0;
        if (r) begin
            owner = -1;
            cnt   = 0;
            ptr   = 0;
        end else if (owner < 0) begin
            if (|req) grant_to(req, ptr);
        end else begin
            if (ea != 0) cnt++;
            lim = ea != 0 && cnt >= MB && !lock_v[owner];
            if (!req[owner] || lim) begin
                m = req;
                if (lim) m[owner] = 1'b0;
                ptr = (owner + 1) % N;
                grant_to(m, ptr);
            end
        end
        @(posedge wclk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && !quiet(); k++) cycle(100, 1'b0, 1'b0);
        if (!quiet()) check("drain_timeout", 0, 1);
    endtask

    task automatic run_pattern(input int n, input string tag, input logic [31:0] exp);
        pat = '0;
        for (int c = 0; c < n; c++) cycle(100, 1'b0, 1'b0);
        check(tag, pat, exp);
        drain();
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            left[i] = 1;
            has[i]  = 1'b0;
            wd[i]   = '0;
            wt[i]   = 0;
        end
        @(posedge wclk);
        #1;
        cycle(100, 1'b0, 1'b1);
        cycle(100, 1'b0, 1'b1);
        cycle(100, 1'b0, 1'b0);
        check("first_gnt", 32'(gnt), 32'h1);
        drain();

        left[2] = 10;
        run_pattern(14, "stream_pattern", 32'b01111011110110);

        for (int i = 0; i < N; i++) left[i] = 4;
        run_pattern(18, "rr_pattern", 32'b011111111111111110);

        left[1] = 4;
        pat = '0;
        for (int c = 0; c < 11; c++) cycle(100, c >= 3 && c <= 7, 1'b0);
        check("full_stall_pattern", pat, 32'b01100000110);
        drain();

        left[2] = 1;
        left[0] = 1;
        pat = '0;
        for (int c = 0; c < 3; c++) cycle(100, 1'b0, 1'b0);
        check("early_regrant", 32'(gnt), 32'h1);
        for (int c = 0; c < 2; c++) cycle(100, 1'b0, 1'b0);
        check("early_pattern", pat, 32'b01010);
        drain();

`ifdef FIFO_WR_ARB_LOCK_EN
        lock_v  = 4'b1000;
        left[3] = 9;
        run_pattern(11, "lock_pattern", 32'b01111111110);
        lock_v  = '0;
        left[3] = 9;
        run_pattern(13, "unlock_pattern", 32'b0111101111010);
`endif

        for (int i = 0; i < N; i++) left[i] = 1000;
        for (int c = 0; c < 3000; c++)
            cycle(60, $urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0);
        for (int i = 0; i < N; i++) left[i] = 0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
